// File: rtl/cic_decim_ctrl_if.sv
// Handshake and control bundle between the CIC sequencing controller and
// the sample source / integrator / comb stages it drives.
// slave  : the controller side (takes configuration and samples).
// master : the source/datapath side.
interface cic_decim_ctrl_if #(
  parameter int R_BITS = 7
);
  logic [R_BITS-1:0] cfg_ratio;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              in_valid;
  logic              integ_en;
  logic              integ_clr;
  logic              comb_en;
  logic              out_valid;
  logic              busy;
  logic [R_BITS-1:0] ratio_q;
  logic              cfg_err;

  modport slave (
    input  cfg_ratio, cfg_valid, in_valid,
    output cfg_ready, integ_en, integ_clr, comb_en, out_valid,
           busy, ratio_q, cfg_err
  );

  modport master (
    output cfg_ratio, cfg_valid, in_valid,
    input  cfg_ready, integ_en, integ_clr, comb_en, out_valid,
           busy, ratio_q, cfg_err
  );
endinterface

// File: rtl/cic_decim_ctrl.sv
// CIC decimation sequencing controller.
// Holds the runtime ratio, gates the integrators, issues the decimation
// strobe to the comb chain and masks comb outputs until STAGES strobes have
// flushed the comb pipeline after every (re)configuration.
// Optional feature macro: CIC_CTRL_DROP_CNT_EN adds a saturating 16-bit
// count of in_valid cycles that were not qualified (drop_cnt).
module cic_decim_ctrl #(
  parameter int MAX_R  = 64,
  parameter int R_BITS = $clog2(MAX_R) + 1,
  parameter int STAGES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  cic_decim_ctrl_if.slave   bus
`ifdef CIC_CTRL_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int SC_W = $clog2(STAGES + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, SETTLE, RUN} state_t;

  state_t            state, state_nxt;
  logic [R_BITS-1:0] phase;
  logic [R_BITS-1:0] phase_inc;
  logic [SC_W-1:0]   settle_cnt;
  logic [R_BITS-1:0] ratio_q;

  logic cfg_ready;
  logic accept;
  logic legal;
  logic q;
  logic strobe;

  logic integ_clr_p1;
  logic comb_en_p1;
  logic out_valid_p1;
  logic cfg_err_p1;

  // Saturating +1 used by the drop counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Handshake, sample qualification and next-state decode.
  always_comb begin
    state_nxt = state;
    cfg_ready = (state != CLEAR);
    accept    = bus.cfg_valid && cfg_ready;
    legal     = (bus.cfg_ratio >= R_BITS'(1)) && (bus.cfg_ratio <= R_BITS'(MAX_R));
    // Reconfiguration wins over data: an accept cycle never qualifies a sample.
    q         = bus.in_valid && ((state == SETTLE) || (state == RUN)) && !accept;
    strobe    = q && (phase == '0);
    phase_inc = phase + R_BITS'(1);

    unique case (state)
      IDLE:   if (accept && legal) state_nxt = CLEAR;
      CLEAR:  state_nxt = SETTLE;
      SETTLE: begin
        if (accept && legal)
          state_nxt = CLEAR;
        else if (strobe && (settle_cnt == SC_W'(STAGES - 1)))
          state_nxt = RUN;
      end
      RUN:    if (accept && legal) state_nxt = CLEAR;
      default: state_nxt = IDLE;
    endcase
  end

  // State, ratio, phase/settle counters and registered strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      phase        <= '0;
      settle_cnt   <= '0;
      ratio_q      <= '0;
      integ_clr_p1 <= 1'b0;
      comb_en_p1   <= 1'b0;
      out_valid_p1 <= 1'b0;
      cfg_err_p1   <= 1'b0;
    end else begin
      state        <= state_nxt;
      integ_clr_p1 <= accept && legal;
      cfg_err_p1   <= accept && !legal;
      comb_en_p1   <= strobe;
      out_valid_p1 <= strobe && (state == RUN);

      if (accept && legal)
        ratio_q <= bus.cfg_ratio;

      if (state == CLEAR) begin
        phase      <= '0;
        settle_cnt <= '0;
      end else if (q) begin
        phase <= (phase_inc == ratio_q) ? '0 : phase_inc;
        if (strobe && (state == SETTLE))
          settle_cnt <= settle_cnt + SC_W'(1);
      end
    end
  end

`ifdef CIC_CTRL_DROP_CNT_EN
  // Count upstream samples that arrived while the integrators were gated.
  always_ff @(posedge clk) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (bus.in_valid && !q)
      drop_cnt <= sat_inc16(drop_cnt);
  end
`endif

  assign bus.cfg_ready = cfg_ready;
  assign bus.integ_en  = q;
  assign bus.integ_clr = integ_clr_p1;
  assign bus.comb_en   = comb_en_p1;
  assign bus.out_valid = out_valid_p1;
  assign bus.busy      = (state == CLEAR) || (state == SETTLE);
  assign bus.ratio_q   = ratio_q;
  assign bus.cfg_err   = cfg_err_p1;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed testbench for cic_decim_ctrl (MAX_R=64, STAGES=3).
// Inputs change on the falling edge; outputs are sampled 1 time unit later,
// so registered outputs show the result of the preceding rising edge.
module tb_cic_decim_ctrl;
  localparam int R_BITS = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  cic_decim_ctrl_if #(.R_BITS(R_BITS)) bus ();
`ifdef CIC_CTRL_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  cic_decim_ctrl #(.MAX_R(64), .R_BITS(R_BITS), .STAGES(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave)
`ifdef CIC_CTRL_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge, then let outputs settle.
  task automatic step(input logic iv, input logic cv, input logic [R_BITS-1:0] r);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.cfg_valid = cv;
    bus.cfg_ratio = r;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    do_reset();
    step(1'b0, 1'b0, '0);
    obs = {bus.integ_clr, bus.comb_en, bus.out_valid, bus.cfg_err, bus.busy};
    n_cmp++;
    if (obs !== 5'b0) begin
      $display("FAIL reset_outputs got=%b want=00000", obs); n_fail++;
    end
    n_cmp++;
    if (bus.ratio_q !== 7'd0 || bus.cfg_ready !== 1'b1) begin
      $display("FAIL reset_ratio_ready ratio_q=%0d ready=%b want 0/1", bus.ratio_q, bus.cfg_ready); n_fail++;
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, '0);
      obs = {bus.integ_en, bus.comb_en, bus.out_valid, bus.cfg_ready, 1'b0};
      n_cmp++;
      if (obs !== 5'b00010) begin
        $display("FAIL idle_samples[%0d] {ie,ce,ov,rdy,0} got=%b want=00010", i, obs); n_fail++;
      end
    end
    step(1'b0, 1'b0, '0);
`ifdef CIC_CTRL_DROP_CNT_EN
    n_cmp++;
    if (drop_cnt !== 16'd10) begin
      $display("FAIL drop_cnt got=%0d want=10", drop_cnt); n_fail++;
    end
`endif
  endtask

  task automatic test_ratio4();
    logic [4:0] obs, exp;
    logic ce;
    do_reset();
    step(1'b1, 1'b1, 7'd4);            // accept cycle, sample not qualified
    n_cmp++;
    if (bus.integ_en !== 1'b0 || bus.cfg_ready !== 1'b1) begin
      $display("FAIL r4_accept ie=%b rdy=%b want 0/1", bus.integ_en, bus.cfg_ready); n_fail++;
    end
    step(1'b1, 1'b0, '0);              // CLEAR
    obs = {bus.integ_en, bus.integ_clr, bus.cfg_ready, bus.busy, 1'b0};
    n_cmp++;
    if (obs !== 5'b01010 || bus.ratio_q !== 7'd4) begin
      $display("FAIL r4_clear {ie,clr,rdy,busy,0}=%b ratio=%0d want 01010/4", obs, bus.ratio_q); n_fail++;
    end
    for (int n = 0; n < 20; n++) begin
      step(1'b1, 1'b0, '0);
      ce  = (n >= 1) && ((n - 1) % 4 == 0);
      exp = {1'b1, 1'b0, ce, ce && (n - 1 >= 12), (n <= 8)};
      obs = {bus.integ_en, bus.integ_clr, bus.comb_en, bus.out_valid, bus.busy};
      n_cmp++;
      if (obs !== exp) begin
        $display("FAIL r4_sample[%0d] {ie,clr,ce,ov,busy} got=%b want=%b", n, obs, exp); n_fail++;
      end
    end
  endtask

  task automatic test_ratio1();
    logic [4:0] obs, exp;
    do_reset();
    step(1'b0, 1'b1, 7'd1);
    step(1'b0, 1'b0, '0);              // CLEAR
    n_cmp++;
    if (bus.integ_clr !== 1'b1 || bus.ratio_q !== 7'd1) begin
      $display("FAIL r1_clear clr=%b ratio=%0d want 1/1", bus.integ_clr, bus.ratio_q); n_fail++;
    end
    for (int n = 0; n < 8; n++) begin
      step(1'b1, 1'b0, '0);
      exp = {1'b1, 1'b0, (n >= 1), (n >= 4), (n <= 2)};
      obs = {bus.integ_en, bus.integ_clr, bus.comb_en, bus.out_valid, bus.busy};
      n_cmp++;
      if (obs !== exp) begin
        $display("FAIL r1_sample[%0d] {ie,clr,ce,ov,busy} got=%b want=%b", n, obs, exp); n_fail++;
      end
    end
  endtask

  // Runs straight after test_ratio1: controller is in RUN with ratio 1.
  task automatic test_bad_ratio();
    logic [R_BITS-1:0] bad [2];
    bad[0] = 7'd0;
    bad[1] = 7'd65;
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b1, bad[k]);
      step(1'b0, 1'b0, '0);
      n_cmp++;
      if (bus.cfg_err !== 1'b1 || bus.integ_clr !== 1'b0 || bus.ratio_q !== 7'd1 || bus.busy !== 1'b0) begin
        $display("FAIL bad_ratio_%0d err=%b clr=%b ratio=%0d busy=%b want 1/0/1/0",
                 bad[k], bus.cfg_err, bus.integ_clr, bus.ratio_q, bus.busy); n_fail++;
      end
      step(1'b0, 1'b0, '0);
      n_cmp++;
      if (bus.cfg_err !== 1'b0) begin
        $display("FAIL bad_ratio_%0d_pulse err=%b want=0", bad[k], bus.cfg_err); n_fail++;
      end
    end
    step(1'b0, 1'b1, 7'd64);           // largest legal ratio
    step(1'b0, 1'b0, '0);
    n_cmp++;
    if (bus.cfg_err !== 1'b0 || bus.integ_clr !== 1'b1 || bus.ratio_q !== 7'd64) begin
      $display("FAIL ratio_64 err=%b clr=%b ratio=%0d want 0/1/64", bus.cfg_err, bus.integ_clr, bus.ratio_q); n_fail++;
    end
  endtask

  task automatic test_reconfig();
    logic [4:0] obs, exp;
    logic ce;
    do_reset();
    step(1'b0, 1'b1, 7'd8);
    step(1'b0, 1'b0, '0);
    for (int n = 0; n < 24; n++) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 7'd2);            // would be a phase-0 sample
    n_cmp++;
    if (bus.integ_en !== 1'b0 || bus.busy !== 1'b0) begin
      $display("FAIL reconfig_accept ie=%b busy=%b want 0/0", bus.integ_en, bus.busy); n_fail++;
    end
    step(1'b1, 1'b0, '0);
    obs = {bus.integ_en, bus.integ_clr, bus.comb_en, bus.out_valid, bus.busy};
    n_cmp++;
    if (obs !== 5'b01001 || bus.ratio_q !== 7'd2) begin
      $display("FAIL reconfig_clear {ie,clr,ce,ov,busy}=%b ratio=%0d want 01001/2", obs, bus.ratio_q); n_fail++;
    end
    for (int n = 0; n < 8; n++) begin
      step(1'b1, 1'b0, '0);
      ce  = (n >= 1) && ((n - 1) % 2 == 0);
      exp = {1'b1, 1'b0, ce, ce && (n - 1 >= 6), (n <= 4)};
      obs = {bus.integ_en, bus.integ_clr, bus.comb_en, bus.out_valid, bus.busy};
      n_cmp++;
      if (obs !== exp) begin
        $display("FAIL r2_sample[%0d] {ie,clr,ce,ov,busy} got=%b want=%b", n, obs, exp); n_fail++;
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1'b1, 1'b1, 7'd4);
    step(1'b1, 1'b1, 7'd2);            // CLEAR: request held, not accepted
    n_cmp++;
    if (bus.cfg_ready !== 1'b0 || bus.ratio_q !== 7'd4) begin
      $display("FAIL b2b_clear rdy=%b ratio=%0d want 0/4", bus.cfg_ready, bus.ratio_q); n_fail++;
    end
    step(1'b1, 1'b1, 7'd2);            // first SETTLE cycle: accepted
    n_cmp++;
    if (bus.cfg_ready !== 1'b1 || bus.integ_en !== 1'b0) begin
      $display("FAIL b2b_settle rdy=%b ie=%b want 1/0", bus.cfg_ready, bus.integ_en); n_fail++;
    end
    step(1'b1, 1'b0, '0);
    n_cmp++;
    if (bus.integ_clr !== 1'b1 || bus.ratio_q !== 7'd2 || bus.comb_en !== 1'b0) begin
      $display("FAIL b2b_second_clear clr=%b ratio=%0d ce=%b want 1/2/0", bus.integ_clr, bus.ratio_q, bus.comb_en); n_fail++;
    end
  endtask

  task automatic test_reset_mid_settle();
    logic [5:0] obs;
    do_reset();
    step(1'b0, 1'b1, 7'd4);
    step(1'b0, 1'b0, '0);
    for (int n = 0; n < 5; n++) step(1'b1, 1'b0, '0);
    rst_n = 1'b0;
    step(1'b1, 1'b0, '0);
    rst_n = 1'b1;
    step(1'b1, 1'b0, '0);
    obs = {bus.integ_en, bus.integ_clr, bus.comb_en, bus.out_valid, bus.cfg_err, bus.busy};
    n_cmp++;
    if (obs !== 6'b0 || bus.ratio_q !== 7'd0 || bus.cfg_ready !== 1'b1) begin
      $display("FAIL mid_settle_reset {ie,clr,ce,ov,err,busy}=%b ratio=%0d rdy=%b want 000000/0/1",
               obs, bus.ratio_q, bus.cfg_ready); n_fail++;
    end
    for (int n = 0; n < 5; n++) begin
      step(1'b1, 1'b0, '0);
      n_cmp++;
      if (bus.integ_en !== 1'b0 || bus.comb_en !== 1'b0 || bus.busy !== 1'b0) begin
        $display("FAIL post_reset_idle[%0d] ie=%b ce=%b busy=%b want 0/0/0",
                 n, bus.integ_en, bus.comb_en, bus.busy); n_fail++;
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_ratio = '0;
    test_reset();
    test_ratio4();
    test_ratio1();
    test_bad_ratio();
    test_reconfig();
    test_back_to_back();
    test_reset_mid_settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cic_decim_ctrl.md
# cic_decim_ctrl

Sequencing controller for the CIC decimation datapath: holds the runtime decimation ratio, gates the integrator chain, issues the decimation strobe to the comb chain, and masks comb outputs until the comb pipeline has settled after every (re)configuration. It sits between the upstream sample source and the integrator, downsample and comb stages. It owns all enables and clears for those stages; they carry no rate logic of their own.

## Interface
- `MAX_R`, 64, largest legal decimation ratio
- `R_BITS`, `$clog2(MAX_R)+1`, width of ratio and phase counter
- `STAGES`, 3, comb-pipeline depth; number of comb strobes discarded after a reconfiguration
- `clk` in 1: single clock; all logic on rising edge
- `rst_n` in 1: synchronous, active-low reset
- `cfg_ratio` in R_BITS: requested decimation ratio R
- `cfg_valid` in 1: configuration request
- `cfg_ready` out 1: controller can accept a configuration
- `in_valid` in 1: upstream sample strobe
- `integ_en` out 1: integrator update enable (combinational)
- `integ_clr` out 1: integrator/comb state clear (registered)
- `comb_en` out 1: decimated strobe to comb chain (registered)
- `out_valid` out 1: comb output is valid (registered, subset of `comb_en`)
- `busy` out 1: state is CLEAR or SETTLE
- `ratio_q` out R_BITS: ratio in force
- `cfg_err` out 1: one-cycle pulse, rejected ratio

## Operation
- States: IDLE, CLEAR, SETTLE, RUN.
- Reset (`rst_n`=0 at an edge) applies in any state, including mid-SETTLE/RUN:
  - state IDLE; phase, settle count and `ratio_q` = 0.
  - `integ_clr`, `comb_en`, `out_valid`, `cfg_err` = 0.
- `cfg_ready` = 1 in IDLE, SETTLE and RUN; 0 in CLEAR. Accept = `cfg_valid && cfg_ready`.
- Legal ratio: 1 ≤ `cfg_ratio` ≤ MAX_R.
  - Legal accept: `ratio_q` ← `cfg_ratio`; next state CLEAR.
  - Illegal accept (0 or > MAX_R): `cfg_err` = 1 next cycle; state and `ratio_q` unchanged.
- CLEAR (exactly 1 cycle):
  - `integ_clr` = 1.
  - phase ← 0; settle count ← 0.
  - `in_valid` ignored.
  - Next state SETTLE.
- Qualified sample `q` = `in_valid && state∈{SETTLE,RUN} && !accept`.
- `integ_en` = `q`. `integ_en` is 0 in IDLE, CLEAR, and on any accept cycle; reconfiguration wins over data.
- On `q`:
  - If phase==0, `comb_en` = 1 next cycle.
  - phase ← (phase+1 == `ratio_q`) ? 0 : phase+1.
  - R=1 gives a strobe on every sample.
- Settling:
  - In SETTLE, each issued `comb_en` increments settle count. `out_valid` stays 0.
  - The strobe that brings the count to STAGES moves the state to RUN.
  - In RUN, `out_valid` = `comb_en`.
- A legal accept in SETTLE or RUN restarts through CLEAR. Pending phase/settle progress is discarded.
- Settle count width: `$clog2(STAGES+1)`. Phase never reaches `ratio_q`.

## Timing
- `integ_en`: zero latency from `in_valid`.
- `comb_en` and `out_valid`: 1 cycle after the qualifying `in_valid`.
- Config latency:
  - Accept at cycle t gives CLEAR at t+1 (`integ_clr` high at t+1).
  - First qualified sample is possible at t+2.
- After a legal config, the first `out_valid` follows the (STAGES+1)-th decimation strobe, i.e. sample index STAGES·R (0-based).
- Back-to-back configs: accept in CLEAR is impossible (`cfg_ready`=0). A request held through CLEAR is accepted on the first SETTLE cycle.
- `cfg_err` never coincides with a state change.

## Configuration
- `CIC_CTRL_DROP_CNT_EN` defined:
  - Adds output `drop_cnt` [15:0].
  - Counts `in_valid` cycles not qualified (IDLE, CLEAR, accept cycles).
  - Saturates at 16'hFFFF; cleared only by reset.
- Not defined: port and counter absent; behaviour otherwise identical.

## Test plan
- Reset, then `in_valid` high 10 cycles with no config:
  - `integ_en`, `comb_en`, `out_valid` all 0; `cfg_ready`=1.
  - with macro: `drop_cnt`=10.
- Config R=4, STAGES=3, continuous `in_valid`:
  - `integ_clr` one pulse.
  - `comb_en` every 4th sample.
  - `out_valid` first on the 4th `comb_en` (sample 12), then every 4 cycles.
  - `busy` falls with the 3rd strobe.
- Config R=1:
  - `comb_en` every cycle after CLEAR; first `out_valid` on the 4th sample.
- `cfg_ratio`=0, then 65 (MAX_R=64):
  - each gives a 1-cycle `cfg_err`; `ratio_q` unchanged; no `integ_clr`.
- In RUN with R=8, reconfig to R=2 on a cycle with `in_valid`=1:
  - that sample not qualified (`integ_en`=0); no `comb_en` next cycle; CLEAR; then strobes every 2 samples.
- `rst_n` low for 1 cycle mid-SETTLE:
  - all outputs 0, state IDLE, `ratio_q`=0.
  - subsequent `in_valid` ignored until a new config.
